// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM states, write-select codes, cache line type.
package mem_bus_arbiter_pkg;

    localparam int CACHE_LINE_W = 128;

    typedef logic [CACHE_LINE_W-1:0] cache_line_t;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_IF_XFER,
        ARB_D_WR,
        ARB_D_RD,
        ARB_DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        no_sel        = 2'b00,
        byte_sel      = 2'b01,
        half_word_sel = 2'b10,
        word_sel      = 2'b11
    } sel_t;

    typedef enum logic {
        WIN_D  = 1'b0,
        WIN_IF = 1'b1
    } winner_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFF0;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// arb_timeout_cnt: loadable down-counter that flags expiry when it reaches zero.
module arb_timeout_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;

    // Loaded with TIMEOUT-1 so the first bus cycle counts as one; zero marks the last allowed cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= LOAD_VAL;
        end else if (load) begin
            count_q <= LOAD_VAL;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory port between IF line refills and MEM-stage refills/stores.
// Define MEM_ARB_RR_EN for round-robin between IF and data classes; default is fixed data-over-IF.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int LINE_W  = CACHE_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_done_o,
    output logic [LINE_W-1:0] if_rdata_o,
    input  logic              d_rd_req_i,
    input  logic              d_wr_req_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wr_data_i,
    input  logic [1:0]        d_wr_sel_i,
    output logic              d_done_o,
    output logic [LINE_W-1:0] d_rdata_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [31:0]       bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    output logic [1:0]        bus_sel_o,
    input  logic              bus_ack_i,
    input  logic [LINE_W-1:0] bus_rdata_i,
    output logic              stall_if_o,
    output logic              stall_mem_o
);

    arb_state_t        state_q, state_d;
    winner_t           win_q;
    logic              we_q, err_q;
    logic [31:0]       addr_q, wdata_q;
    sel_t              sel_q;
    logic [LINE_W-1:0] if_rdata_q, d_rdata_q;
    logic              in_xfer, expired, d_pend, pick_d, cnt_load;

    assign d_pend   = d_wr_req_i | d_rd_req_i;
    assign in_xfer  = (state_q == ARB_IF_XFER) || (state_q == ARB_D_WR) || (state_q == ARB_D_RD);
    assign cnt_load = (state_q == ARB_IDLE);

`ifdef MEM_ARB_RR_EN
    winner_t last_win_q;

    // Data yields to IF only when both classes wait and data won last time.
    assign pick_d = d_pend & ~(if_req_i & (last_win_q == WIN_D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_win_q <= WIN_D;
        end else if (state_q == ARB_DONE) begin
            last_win_q <= win_q;
        end
    end
`else
    assign pick_d = d_pend;
`endif

    arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .en      (in_xfer),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_d) begin
                    state_d = d_wr_req_i ? ARB_D_WR : ARB_D_RD;
                end else if (if_req_i) begin
                    state_d = ARB_IF_XFER;
                end
            end
            ARB_IF_XFER, ARB_D_WR, ARB_D_RD: begin
                if (bus_ack_i || expired) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // NOTE: the rdata registers drive outputs with defined reset values, so they are reset too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q      <= WIN_D;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= no_sel;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    err_q <= 1'b0;
                    if (state_d == ARB_D_WR) begin
                        win_q   <= WIN_D;
                        we_q    <= 1'b1;
                        addr_q  <= d_addr_i;
                        wdata_q <= d_wr_data_i;
                        sel_q   <= sel_t'(d_wr_sel_i);
                    end else if (state_d == ARB_D_RD) begin
                        win_q   <= WIN_D;
                        we_q    <= 1'b0;
                        addr_q  <= line_align(d_addr_i);
                        wdata_q <= '0;
                        sel_q   <= no_sel;
                    end else if (state_d == ARB_IF_XFER) begin
                        win_q   <= WIN_IF;
                        we_q    <= 1'b0;
                        addr_q  <= line_align(if_addr_i);
                        wdata_q <= '0;
                        sel_q   <= no_sel;
                    end
                end
                ARB_IF_XFER, ARB_D_WR, ARB_D_RD: begin
                    // Ack wins over a simultaneous expiry.
                    if (bus_ack_i) begin
                        if (win_q == WIN_IF) if_rdata_q <= bus_rdata_i;
                        else                 d_rdata_q  <= bus_rdata_i;
                    end else if (expired) begin
                        err_q <= 1'b1;
                        if (win_q == WIN_IF) if_rdata_q <= '0;
                        else                 d_rdata_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_req_o   = in_xfer;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_sel_o   = sel_q;
    assign if_done_o   = (state_q == ARB_DONE) && (win_q == WIN_IF);
    assign d_done_o    = (state_q == ARB_DONE) && (win_q == WIN_D);
    assign err_o       = (state_q == ARB_DONE) && err_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign stall_if_o  = if_req_i & ~if_done_o;
    assign stall_mem_o = d_pend & ~d_done_o;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences and shares the single external memory port between instruction fetch (cache-line refills) and the MEM stage (data-cache refills and write-through stores). It sits between the IF/MEM stages and the memory bus. It serialises requests through a small FSM, enforces a bus timeout, and generates per-requester done/stall signals so the pipeline freezes while its access is outstanding.

## Interface
Parameters:
- `TIMEOUT`, 64: cycles to wait for `bus_ack_i` before aborting with error.
- `LINE_W`, 128: refill line width (matches `CacheLine`).

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous reset, active-high
- `if_req_i`  in  1  instruction line-refill request, held until `if_done_o`
- `if_addr_i`  in  32  line address (low 4 bits ignored)
- `if_done_o`  out  1  one-cycle pulse: `if_rdata_o` valid, access finished
- `if_rdata_o`  out  LINE_W  refill line
- `d_rd_req_i`  in  1  data line-refill request (cache miss), held until `d_done_o`
- `d_wr_req_i`  in  1  write-through store request, held until `d_done_o`
- `d_addr_i`  in  32  data address
- `d_wr_data_i`  in  32  store data, already aligned
- `d_wr_sel_i`  in  2  byte/half/word select (`no_sel`/`byte_sel`/`half_word_sel`/`word_sel`)
- `d_done_o`  out  1  one-cycle completion pulse
- `d_rdata_o`  out  LINE_W  refill line
- `err_o`  out  1  pulses with the done of an access that timed out
- `bus_req_o`  out  1  bus request, held until ack
- `bus_we_o`  out  1  1 = write
- `bus_addr_o`  out  32  bus address (line-aligned for reads)
- `bus_wdata_o`  out  32  write data
- `bus_sel_o`  out  2  write select
- `bus_ack_i`  in  1  bus completes the current transfer
- `bus_rdata_i`  in  LINE_W  read line, valid with `bus_ack_i`
- `stall_if_o`  out  1  `if_req_i & ~if_done_o` (combinational)
- `stall_mem_o`  out  1  `(d_rd_req_i | d_wr_req_i) & ~d_done_o` (combinational)

## Operation
- FSM states: IDLE, IF_XFER, D_WR, D_RD, DONE.
- IDLE: picks a winner among the pending requests. The winner's address, data, sel and type are registered, and the FSM moves to the matching XFER state. With no request pending, the FSM stays in IDLE.
- Default priority: D_WR > D_RD > IF.
- With `d_wr_req_i` and `d_rd_req_i` both asserted, the write is serviced first. `d_done_o` pulses once per access, so the requester sees two pulses and holds the read request after the first.
- XFER states: `bus_req_o`=1 and the bus fields are driven from the registers, stable until ack.
- On `bus_ack_i`: capture `bus_rdata_i` into the winner's rdata register and go to DONE.
- On the timeout counter reaching `TIMEOUT-1` without ack: deassert `bus_req_o`, set the error flag, return zero rdata, and go to DONE.
- DONE: the winner's done pulses for one cycle, together with `err_o` if flagged. The FSM then returns to IDLE, and requests are re-evaluated in the IDLE cycle that follows.
- Reads: `bus_addr_o` = `{addr[31:4],4'b0}`, `bus_we_o`=0, `bus_sel_o`=`no_sel`.
- `bus_ack_i` outside the XFER states is ignored.
- A requester dropping its request mid-transfer is illegal. The transfer still completes, and the done pulse is still issued.
- Async reset: the FSM goes to IDLE immediately and all outputs take their reset values.
- Reset values: `bus_req_o`=0, `bus_we_o`=0, `bus_addr_o`=0, `bus_wdata_o`=0, `bus_sel_o`=`no_sel`, `if_done_o`=0, `d_done_o`=0, `err_o`=0, `if_rdata_o`=0, `d_rdata_o`=0.

## Timing
- Cycle 0: request seen in IDLE.
- Cycle 1: `bus_req_o` high.
- Ack in cycle k (k ≥ 1) → done in cycle k+1.
- Minimum access: 3 cycles from request to done (ack in cycle 1); the FSM is back in IDLE at cycle 3.
- Timeout: `bus_req_o` is high for exactly `TIMEOUT` cycles, and done follows one cycle later.
- rdata registers hold their value until the next capture.
- The timeout counter clears on entry to XFER. Its width is `$clog2(TIMEOUT)`.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin between the IF and data classes. A 1-bit last-winner register is updated in DONE; data-class winner preference (write before read) is unchanged.
- Undefined: fixed priority, data over IF. IF can starve while MEM keeps requesting.

## Structure
- Shared package/`define.v`:
  - FSM state encodings (`ARB_IDLE`, `ARB_IF_XFER`, `ARB_D_WR`, `ARB_D_RD`, `ARB_DONE`)
  - `no_sel`/`byte_sel`/`half_word_sel`/`word_sel`
  - `CacheLine`
- Sub-module: `arb_timeout_cnt`, a loadable down-counter with an expiry flag.

## Test plan
- IF request only, addr 0x0000_1234, ack in cycle 2 with rdata 0x0123…CDEF → `bus_addr_o`=0x0000_1230, `if_done_o` in cycle 3 with that rdata, `stall_if_o` high in cycles 0–2.
- `d_wr_req_i` and `if_req_i` both at cycle 0, store 0xDEADBEEF, `byte_sel` → bus write first with `bus_we_o`=1 and sel=`byte_sel`; IF serviced afterwards.
- `d_wr_req_i` and `d_rd_req_i` together → write completes with a `d_done_o` pulse, then the read issues with a second `d_done_o` pulse.
- No ack, `TIMEOUT`=64 → `bus_req_o` high for 64 cycles, then `d_done_o` and `err_o` pulse together with rdata 0.
- Async reset asserted in mid-XFER → `bus_req_o`=0 in the same cycle; after release, the held request is re-arbitrated from IDLE.
- With `MEM_ARB_RR_EN`, IF and data reads requested continuously → grants alternate IF/D; without it, only D is granted.
